// File: rtl/sram_burst_ctrl.sv
// Burst initiator for a 2048x64 single-port SRAM: streams writes or reads through a 2-entry read FIFO.
// Optional address wrap-around is enabled by defining SRAM_BURST_WRAP_EN.
module sram_burst_ctrl #(
   parameter int NUM_WORD = 2048,
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 64,
   parameter int LEN_W    = 12
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              CEB,
   output logic              WEB,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   input  logic [DATA_W-1:0] Q
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] a_hold;
   logic [DATA_W-1:0] d_hold;
   logic [LEN_W-1:0]  remain;
   logic              inflight;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              fifo_wp;
   logic              fifo_rp;
   logic [1:0]        fifo_cnt;
   logic [2:0]        occ;
   logic              wr_fire;
   logic              rd_pop;
   logic              rd_issue;
   logic              access;
   logic              cmd_fire;
   logic              last_word;
   logic              range_bad;

`ifdef SRAM_BURST_WRAP_EN
   assign range_bad = 1'b0;
`else
   logic [LEN_W:0] end_sum;
   assign end_sum   = (LEN_W+1)'(cmd_addr) + (LEN_W+1)'(cmd_len);
   assign range_bad = end_sum > (LEN_W+1)'(NUM_WORD);
`endif

   // Access strobes are gated by RSTN so the macro is never touched while reset is asserted.
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign wr_fire   = RSTN && wr_ready && wr_valid;
   assign rd_pop    = rd_valid && rd_ready;
   assign occ       = 3'(fifo_cnt) + 3'(inflight) - 3'(rd_pop);
   assign rd_issue  = RSTN && (state == S_READ) && (occ < 3'd2);
   assign access    = wr_fire || rd_issue;
   assign last_word = (remain == LEN_W'(1));

   assign CEB      = !access;
   assign WEB      = !wr_fire;
   assign A        = access ? ptr : a_hold;
   assign D        = wr_fire ? wr_data : d_hold;
   assign rd_valid = (fifo_cnt != 2'd0);
   assign rd_data  = fifo_mem[fifo_rp];
   assign busy     = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (RSTN && inflight) begin
         fifo_mem[fifo_wp] <= Q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b0;
         wr_ready  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         inflight  <= 1'b0;
         fifo_wp   <= 1'b0;
         fifo_rp   <= 1'b0;
         fifo_cnt  <= 2'd0;
         ptr       <= '0;
         remain    <= '0;
         a_hold    <= '0;
         d_hold    <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         inflight <= rd_issue;
         if (access) a_hold <= ptr;
         if (wr_fire) d_hold <= wr_data;
         if (inflight) fifo_wp <= !fifo_wp;
         if (rd_pop) fifo_rp <= !fifo_rp;
         fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(rd_pop);

         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_fire) begin
                  ptr    <= cmd_addr;
                  remain <= cmd_len;
                  if (range_bad) begin
                     err <= 1'b1;
                  end else if (cmd_len == '0) begin
                     done <= 1'b1;
                  end else if (cmd_write) begin
                     state     <= S_WRITE;
                     wr_ready  <= 1'b1;
                     cmd_ready <= 1'b0;
                  end else begin
                     state     <= S_READ;
                     cmd_ready <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               if (wr_fire) begin
                  ptr    <= ptr + ADDR_W'(1);
                  remain <= remain - LEN_W'(1);
                  if (last_word) begin
                     state     <= S_IDLE;
                     wr_ready  <= 1'b0;
                     cmd_ready <= 1'b1;
                     done      <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (rd_issue) begin
                  ptr    <= ptr + ADDR_W'(1);
                  remain <= remain - LEN_W'(1);
                  if (last_word) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Leave once nothing is in flight and the final word is being handed over.
               if (!inflight && (fifo_cnt == 2'(rd_pop))) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  done      <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst initiator for the 2048x64 single-port SRAM macro. Accepts one command at a time (start address, length, direction) and drives the macro's CEB/WEB/A/D pins. It either streams write data from a valid/ready producer into consecutive words, or reads consecutive words and returns them on a valid/ready consumer port. Sits between the accelerator datapath/DMA and each SRAM bank; it is the only master of the macro pins.

## Interface
- NUM_WORD, 2048, words in the attached SRAM
- ADDR_W, 11, SRAM address width (log2 NUM_WORD)
- DATA_W, 64, SRAM word width
- LEN_W, 12, burst length field width (max NUM_WORD words)

Clock and reset: one clock; reset is synchronous and active-low (CLK, RSTN).

- CLK  in  1  clock; all state updates on posedge
- RSTN  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words; 0 is legal
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_W  write word
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on a rejected command
- CEB, WEB  out  1  SRAM chip/write enable, active-low
- A  out  ADDR_W  SRAM address
- D  out  DATA_W  SRAM write data
- Q  in  DATA_W  SRAM read data, valid the cycle after the read edge

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: accept on cmd_valid&&cmd_ready.
  - Latch addr pointer and remaining count.
  - len==0: pulse done next cycle and stay in IDLE.
  - Otherwise go to WRITE or READ.
- WRITE:
  - wr_ready=1.
  - On each wr handshake: CEB=0, WEB=0, A=ptr, D=wr_data, all combinational in the same cycle, so the word lands at that edge.
  - ptr++, count--. The last handshake returns to IDLE, and done pulses the next cycle.
- READ:
  - Issue a read (CEB=0, WEB=1, A=ptr) when credit is available: buf_cnt + inflight - pop < 2, where pop = rd_valid&&rd_ready in this cycle.
  - Each issue sets inflight for one cycle. Q is pushed into the 2-entry output FIFO on the following edge.
  - After the last issue, go to DRAIN.
- DRAIN: wait until inflight==0 and the FIFO is empty after the final rd handshake, then go to IDLE and pulse done.
- Idle pins: CEB=1 and WEB=1 whenever no access is issued. A and D hold their last value.
- Address arithmetic: ptr is ADDR_W bits and increments modulo NUM_WORD (see Configuration).
- rd_data/rd_valid come from the FIFO head. Data order always equals address order.

## Timing
- Reset values:
  - cmd_ready=0 during reset, 1 the cycle after reset releases.
  - busy=0, done=0, err=0, wr_ready=0, rd_valid=0, CEB=1, WEB=1, A=0, D=0.
  - FIFO empty, inflight=0.
- Command accepted at edge E0; the first SRAM access can occur in the cycle after E0.
- Read latency: issued at edge E1, Q valid after E1, captured at E2, rd_valid high after E2. That is 2 cycles from issue to rd_valid.
- Throughput: 1 word/cycle in both directions with the producer/consumer never stalling.
- rd_ready low: issue stops once credit is exhausted. The FIFO never overflows and no Q sample is lost.
- rd_valid stays high and rd_data stays stable until the handshake.
- wr_valid low stalls with no SRAM access that cycle.
- done pulses exactly once per accepted burst. It is never asserted together with err.
- RSTN low mid-burst:
  - Next edge forces IDLE and empties the FIFO.
  - CEB=1, no done pulse.
  - Any partially written data stays in the SRAM.

## Configuration
- SRAM_BURST_WRAP_EN defined: cmd_addr+cmd_len > NUM_WORD is legal. The address wraps from NUM_WORD-1 to 0, and err is never asserted.
- Undefined: such a command is accepted, err pulses the cycle after acceptance, no SRAM access occurs, and the block stays in IDLE.

## Test plan
- Write then read back, len=8, addr=0x010, data=0x1000+i, continuous valid/ready. Required:
  - CEB low for 8 consecutive cycles.
  - rd_data=0x1000..0x1007 in order.
  - First rd_valid 2 cycles after the first read issue.
  - One done per burst.
- Read len=16 with rd_ready toggling 1-0-0-1 pseudo-randomly. Required: no lost or duplicated words, read issues never exceed credit, rd_data stable while stalled.
- len=0 command. Required: done pulses next cycle, CEB stays 1, cmd_ready returns next cycle.
- addr=0x7FE, len=4. Required:
  - With SRAM_BURST_WRAP_EN: writes hit 0x7FE, 0x7FF, 0x000, 0x001.
  - Without: err pulse, no CEB activity, done=0.
- Assert RSTN=0 after 3 of 10 read words have been issued. Required: next cycle CEB=1, rd_valid=0, busy=0, no done; a new len=2 burst then completes normally.
- Write burst with wr_valid gaps every other cycle, len=5. Required: exactly 5 write accesses at consecutive addresses, done one cycle after the 5th.
